// File: rtl/ai_player.sv
// ---------------------------------------------------------------------------
// ai_player
//   Computer opponent for the tic-tac-toe game controller. On a move request
//   it snapshots the board, scores the nine cells one per cycle, then writes
//   the best cell through the controller's player-input interface. It waits
//   for the board to show that cell occupied before it reports completion.
//
// Handshake with the game controller:
//   playerWrite is a one-cycle strobe, and playerInput is valid while it is
//   high. playerInput then stays stable until the move ends. The controller
//   acknowledges by making the written cell non-empty on gBoard. If that does
//   not happen within ACK_TIMEOUT cycles, timeoutErr is raised.
//
// Parameters:
//   ACK_TIMEOUT  Number of WAIT_ACK cycles allowed before timeoutErr is set.
//
// Optional build macro:
//   AI_RANDOM_TIE_EN  Adds an 8-bit LFSR (taps 8,6,5,4; seed 8'hA5). When a
//                     valid cell scores equal to the current best, it takes
//                     over the best when lfsr[0]=1. Without the macro, ties
//                     keep the lowest index.
//
// Ports:
//   ph1          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   moveReq      in   start a move (sampled in IDLE only)
//   isPlayer1    in   1: AI mark is 2'b11, 0: AI mark is 2'b10
//   gBoard[17:0] in   cell i at [2i+1:2i]; 00 empty, 11 player1, 10 player2
//   gameIsDone   in   aborts any operation in progress
//   playerWrite  out  one-cycle write strobe
//   playerInput  out  chosen cell index 0..8
//   busy         out  high in every state except IDLE
//   moveDone     out  one-cycle pulse when the move is acknowledged
//   noMove       out  board was full; held until the next accepted request
//   timeoutErr   out  ack not seen; held until the next accepted request
//   dbgState     out  current FSM state encoding (debug)
// ---------------------------------------------------------------------------
module ai_player #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        moveReq,
  input  logic        isPlayer1,
  input  logic [17:0] gBoard,
  input  logic        gameIsDone,
  output logic        playerWrite,
  output logic [3:0]  playerInput,
  output logic        busy,
  output logic        moveDone,
  output logic        noMove,
  output logic        timeoutErr,
  output logic [2:0]  dbgState
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SNAP     = 3'd1,
    S_SCAN     = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t        r_state;
  logic [17:0]   r_board;
  logic          r_myP1;
  logic [3:0]    r_idx;
  logic          r_bestValid;
  logic [2:0]    r_bestScore;
  logic [3:0]    r_bestIdx;
  logic [CW-1:0] r_cnt;
  logic          r_playerWrite;
  logic [3:0]    r_playerInput;
  logic          r_busy;
  logic          r_moveDone;
  logic          r_noMove;
  logic          r_timeoutErr;

  // Returns the two-bit contents of cell k. Indices above 8 read as empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] k);
    case (k)
      4'd0:    return b[1:0];
      4'd1:    return b[3:2];
      4'd2:    return b[5:4];
      4'd3:    return b[7:6];
      4'd4:    return b[9:8];
      4'd5:    return b[11:10];
      4'd6:    return b[13:12];
      4'd7:    return b[15:14];
      4'd8:    return b[17:16];
      default: return 2'b00;
    endcase
  endfunction

  // Score of an empty cell k. The result is the best of: win 4, block 3,
  // centre 2, corner 1, edge 0.
  function automatic logic [2:0] cell_score(input logic [17:0] b, input logic [3:0] k,
                                            input logic [1:0] my, input logic [1:0] opp);
    logic       win;
    logic       blk;
    logic       hit;
    logic [3:0] p0, p1, p2, o1, o2;
    win = 1'b0;
    blk = 1'b0;
    for (int l = 0; l < 8; l++) begin
      case (l)
        0:       {p0, p1, p2} = {4'd0, 4'd1, 4'd2};
        1:       {p0, p1, p2} = {4'd3, 4'd4, 4'd5};
        2:       {p0, p1, p2} = {4'd6, 4'd7, 4'd8};
        3:       {p0, p1, p2} = {4'd0, 4'd3, 4'd6};
        4:       {p0, p1, p2} = {4'd1, 4'd4, 4'd7};
        5:       {p0, p1, p2} = {4'd2, 4'd5, 4'd8};
        6:       {p0, p1, p2} = {4'd0, 4'd4, 4'd8};
        default: {p0, p1, p2} = {4'd2, 4'd4, 4'd6};
      endcase
      hit = 1'b1;
      o1  = p1;
      o2  = p2;
      if (k == p0) begin
        o1 = p1; o2 = p2;
      end else if (k == p1) begin
        o1 = p0; o2 = p2;
      end else if (k == p2) begin
        o1 = p0; o2 = p1;
      end else begin
        hit = 1'b0;
      end
      if (hit && cell_at(b, o1) == my  && cell_at(b, o2) == my)  win = 1'b1;
      if (hit && cell_at(b, o1) == opp && cell_at(b, o2) == opp) blk = 1'b1;
    end
    if (win)                                           return 3'd4;
    else if (blk)                                      return 3'd3;
    else if (k == 4'd4)                                return 3'd2;
    else if (k == 4'd0 || k == 4'd2 || k == 4'd6 || k == 4'd8) return 3'd1;
    else                                               return 3'd0;
  endfunction

  logic [1:0]    w_myMark;
  logic [1:0]    w_oppMark;
  logic          w_empty;
  logic [2:0]    w_score;
  logic          w_tieRand;
  logic          w_take;
  logic          w_finalValid;
  logic [3:0]    w_finalIdx;
  logic [CW-1:0] w_cntNext;
  logic          w_acked;

`ifdef AI_RANDOM_TIE_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4. It free-runs every cycle.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_tieRand = r_lfsr[0];
`else
  assign w_tieRand = 1'b0;
`endif

  assign w_myMark  = r_myP1 ? 2'b11 : 2'b10;
  assign w_oppMark = r_myP1 ? 2'b10 : 2'b11;
  assign w_empty   = (cell_at(r_board, r_idx) == 2'b00);
  assign w_score   = cell_score(r_board, r_idx, w_myMark, w_oppMark);
  assign w_take    = w_empty && (!r_bestValid || (w_score > r_bestScore) ||
                                 ((w_score == r_bestScore) && w_tieRand));
  // The best result includes the cell being scored this cycle. This lets
  // the last SCAN cycle (idx 8) go straight to ISSUE with the final index.
  assign w_finalValid = r_bestValid | w_empty;
  assign w_finalIdx   = w_take ? r_idx : r_bestIdx;
  assign w_cntNext    = r_cnt + CW'(1);
  assign w_acked      = (cell_at(gBoard, r_playerInput) != 2'b00);

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_board       <= '0;
      r_myP1        <= 1'b0;
      r_idx         <= '0;
      r_bestValid   <= 1'b0;
      r_bestScore   <= '0;
      r_bestIdx     <= '0;
      r_cnt         <= '0;
      r_playerWrite <= 1'b0;
      r_playerInput <= '0;
      r_busy        <= 1'b0;
      r_moveDone    <= 1'b0;
      r_noMove      <= 1'b0;
      r_timeoutErr  <= 1'b0;
    end else begin
      // Both strobes are single-cycle pulses by default.
      r_playerWrite <= 1'b0;
      r_moveDone    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (moveReq && !gameIsDone) begin
            r_state      <= S_SNAP;
            r_busy       <= 1'b1;
            r_noMove     <= 1'b0;
            r_timeoutErr <= 1'b0;
          end
        end
        S_SNAP: begin
          if (gameIsDone) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_playerInput <= '0;
          end else begin
            r_board     <= gBoard;
            r_myP1      <= isPlayer1;
            r_idx       <= '0;
            r_bestValid <= 1'b0;
            r_bestScore <= '0;
            r_bestIdx   <= '0;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (gameIsDone) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_playerInput <= '0;
          end else begin
            if (w_take) begin
              r_bestValid <= 1'b1;
              r_bestScore <= w_score;
              r_bestIdx   <= r_idx;
            end
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd8) begin
              if (w_finalValid) begin
                r_state       <= S_ISSUE;
                r_playerWrite <= 1'b1;
                r_playerInput <= w_finalIdx;
              end else begin
                r_state  <= S_DONE;
                r_noMove <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (gameIsDone) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_playerInput <= '0;
          end else begin
            r_cnt   <= '0;
            r_state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (gameIsDone) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_playerInput <= '0;
          end else if (w_acked) begin
            r_state    <= S_DONE;
            r_moveDone <= 1'b1;
          end else begin
            r_cnt <= w_cntNext;
            if (w_cntNext == CW'(ACK_TIMEOUT)) begin
              r_state      <= S_DONE;
              r_timeoutErr <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign playerWrite = r_playerWrite;
  assign playerInput = r_playerInput;
  assign busy        = r_busy;
  assign moveDone    = r_moveDone;
  assign noMove      = r_noMove;
  assign timeoutErr  = r_timeoutErr;
  assign dbgState    = r_state;

endmodule

// File: tb/tb_ai_player.sv
// ---------------------------------------------------------------------------
// tb_ai_player
//   Directed scenarios for ai_player, with hand-computed expected moves.
//   Each expected DUT event (write with cell, moveDone, noMove, timeout) is
//   queued when a request is issued. A negedge monitor pops and compares
//   whenever the DUT shows a write strobe or reaches DONE.
//   Event encoding in exp_q: {kind[3:0], cell[3:0]}.
//     kind 1 = write of cell, 2 = moveDone, 3 = noMove, 4 = timeout.
// ---------------------------------------------------------------------------
module tb_ai_player;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic        ph1 = 1'b0;
  logic        reset = 1'b0;
  logic        moveReq = 1'b0;
  logic        isPlayer1 = 1'b0;
  logic [17:0] gBoard = '0;
  logic        gameIsDone = 1'b0;
  logic        playerWrite;
  logic [3:0]  playerInput;
  logic        busy;
  logic        moveDone;
  logic        noMove;
  logic        timeoutErr;
  logic [2:0]  dbgState;

  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  ai_player #(.ACK_TIMEOUT(15)) dut (
    .ph1         (ph1),
    .reset       (reset),
    .moveReq     (moveReq),
    .isPlayer1   (isPlayer1),
    .gBoard      (gBoard),
    .gameIsDone  (gameIsDone),
    .playerWrite (playerWrite),
    .playerInput (playerInput),
    .busy        (busy),
    .moveDone    (moveDone),
    .noMove      (noMove),
    .timeoutErr  (timeoutErr),
    .dbgState    (dbgState)
  );

  // ---------------- clock ----------------
  always #5 ph1 = ~ph1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] put(input logic [17:0] b, input int i, input logic [1:0] v);
    logic [17:0] r;
    r = b;
    r[2*i +: 2] = v;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge ph1) begin
    logic [7:0] ev;
    logic       have;
    have = 1'b0;
    ev   = '0;
    if (!reset) begin
      if (playerWrite) begin
        ev = {4'd1, playerInput};
        have = 1'b1;
      end else if (dbgState == ST_DONE) begin
        ev = moveDone ? 8'h20 : noMove ? 8'h30 : timeoutErr ? 8'h40 : 8'h50;
        have = 1'b1;
      end
      if (have) begin
        if (exp_q.size() == 0) chk("unexpected_event", {24'd0, ev}, 32'd0);
        else                   chk("event", {24'd0, ev}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns one ns after the edge that samples moveReq (edge 0).
  task automatic issue_req();
    @(posedge ph1);
    #1 moveReq = 1'b1;
    @(posedge ph1);
    #1 moveReq = 1'b0;
  endtask

  task automatic run_move(input logic [17:0] b, input logic p1, input logic [3:0] exp_cell,
                          input bit ack, input string tag);
    int k;
    int w;
    int waits;
    gBoard    = b;
    isPlayer1 = p1;
    exp_q.push_back({4'd1, exp_cell});
    exp_q.push_back(ack ? 8'h20 : 8'h40);
    issue_req();
    @(negedge ph1);
    k = 1;
    chk({tag, "_flags_cleared"}, {30'd0, noMove, timeoutErr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!playerWrite && k < 60) begin
      @(negedge ph1);
      k++;
    end
    chk({tag, "_write_latency"}, k, 11);
    if (ack) begin
      @(posedge ph1);
      #1 gBoard = put(gBoard, int'(exp_cell), p1 ? 2'b11 : 2'b10);
    end
    w = 0;
    waits = 0;
    do begin
      @(negedge ph1);
      w++;
      if (dbgState == ST_WAIT) waits++;
    end while (dbgState != ST_DONE && w < 40);
    chk({tag, "_reached_done"}, {29'd0, dbgState}, {29'd0, ST_DONE});
    chk({tag, "_wait_cycles"}, waits, ack ? 1 : 15);
    @(negedge ph1);
    chk({tag, "_idle_after"}, {29'd0, busy, moveDone, playerWrite}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [17:0] b;
    int k;

    #1 reset = 1'b1;
    repeat (3) @(posedge ph1);
    #1;
    chk("reset_outputs",
        {16'd0, playerWrite, playerInput, busy, moveDone, noMove, timeoutErr, dbgState},
        32'd0);
    reset = 1'b0;

    // Empty board: centre wins on score 2.
    run_move(18'd0, 1'b1, 4'd4, 1'b1, "empty");

    // Win at 2 beats the block at 5.
    b = '0;
    b = put(b, 0, 2'b11); b = put(b, 1, 2'b11);
    b = put(b, 3, 2'b10); b = put(b, 4, 2'b10);
    run_move(b, 1'b1, 4'd2, 1'b1, "win_over_block");

    // AI is player2: block the diagonal at 8.
    b = '0;
    b = put(b, 0, 2'b11); b = put(b, 4, 2'b11); b = put(b, 2, 2'b10);
    run_move(b, 1'b0, 4'd8, 1'b1, "block");

    // Centre taken: the corners tie at 1, so the lowest index (0) wins.
    b = put(18'd0, 4, 2'b10);
    run_move(b, 1'b1, 4'd0, 1'b1, "corner_tie");

    // AI is player2 and owns 2 and 6: a diagonal win at the centre.
    b = '0;
    b = put(b, 2, 2'b10); b = put(b, 6, 2'b10);
    b = put(b, 0, 2'b11); b = put(b, 1, 2'b11);
    run_move(b, 1'b0, 4'd4, 1'b1, "diag_win");

    // Only the last cell is free.
    b = '0;
    for (int i = 0; i < 8; i++) b = put(b, i, 2'b10);
    run_move(b, 1'b1, 4'd8, 1'b1, "only_cell8");

    // Only cell 7 is free.
    b = '0;
    for (int i = 0; i < 9; i++) if (i != 7) b = put(b, i, 2'b11);
    run_move(b, 1'b0, 4'd7, 1'b1, "only_cell7");

    // Full board: no write, and noMove is raised after the 9 SCAN cycles.
    gBoard    = 18'h3FFFF;
    isPlayer1 = 1'b1;
    exp_q.push_back(8'h30);
    issue_req();
    k = 0;
    do begin
      @(negedge ph1);
      k++;
    end while (dbgState != ST_DONE && k < 40);
    chk("full_done_cycle", k, 11);
    chk("full_noMove", {31'd0, noMove}, 32'd1);
    repeat (5) @(negedge ph1);
    chk("full_noMove_held", {31'd0, noMove}, 32'd1);
    chk("full_idle", {29'd0, dbgState}, {29'd0, ST_IDLE});

    // A fresh request clears noMove (checked inside run_move).
    run_move(18'd0, 1'b1, 4'd4, 1'b1, "after_full");

    // No acknowledge: timeout after 15 WAIT_ACK cycles, and no moveDone.
    run_move(18'd0, 1'b1, 4'd4, 1'b0, "timeout");
    repeat (4) @(negedge ph1);
    chk("timeout_held", {31'd0, timeoutErr}, 32'd1);

    // gameIsDone is raised during the SCAN cycle for idx 5.
    gBoard = '0;
    issue_req();
    repeat (6) @(posedge ph1);
    #1 gameIsDone = 1'b1;
    @(negedge ph1);
    chk("abort_in_scan", {29'd0, dbgState}, {29'd0, ST_SCAN});
    @(posedge ph1);
    #1;
    chk("abort_outputs",
        {16'd0, playerWrite, playerInput, busy, moveDone, noMove, timeoutErr, dbgState},
        32'd0);
    gameIsDone = 1'b0;
    repeat (20) @(negedge ph1);
    chk("abort_stays_idle", {29'd0, dbgState}, {29'd0, ST_IDLE});

    // Reset during WAIT_ACK: only the write event is expected.
    gBoard = '0;
    exp_q.push_back({4'd1, 4'd4});
    issue_req();
    k = 0;
    while (!playerWrite && k < 60) begin
      @(negedge ph1);
      k++;
    end
    repeat (3) @(posedge ph1);
    #1;
    chk("pre_reset_wait", {29'd0, dbgState}, {29'd0, ST_WAIT});
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {16'd0, playerWrite, playerInput, busy, moveDone, noMove, timeoutErr, dbgState},
        32'd0);
    @(posedge ph1);
    #1 reset = 1'b0;

    // Normal operation after reset.
    run_move(18'd0, 1'b1, 4'd4, 1'b1, "after_reset");

    repeat (5) @(negedge ph1);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ai_player.md
Name: ai_player

Overview:
- Computer opponent for the tic-tac-toe game controller; the board reader / move writer on the controller's player-input interface.
- On request it snapshots the 18-bit board, scores the 9 cells one per cycle, and picks a move.
- It then drives one playerWrite pulse with the chosen cell index and waits for the board to show that cell occupied.

Parameters:
- ACK_TIMEOUT, 15, cycles to wait in WAIT_ACK for the chosen cell to become non-empty before flagging timeoutErr.

Ports:
- ph1  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- moveReq  input  1  start a move; sampled only in IDLE.
- isPlayer1  input  1  1: AI mark is player1 (11); 0: AI mark is player2 (10).
- gBoard  input  18  cell i at gBoard[2i+1:2i], i=0..8 row-major; empty 00, player1 11, player2 10.
- gameIsDone  input  1  game over; aborts any operation.
- playerWrite  output  1  one-cycle write strobe to the game controller.
- playerInput  output  4  chosen cell index 0..8; held stable from ISSUE through WAIT_ACK.
- busy  output  1  high in every state except IDLE.
- moveDone  output  1  one-cycle pulse when the move is acknowledged.
- noMove  output  1  board full at snapshot; held until next accepted moveReq.
- timeoutErr  output  1  ack not seen; held until next accepted moveReq.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; playerInput=0; best-score and index registers cleared.
- States: IDLE, SNAP, SCAN, ISSUE, WAIT_ACK, DONE.
- IDLE, moveReq=1 and gameIsDone=0 -> SNAP. Clears noMove and timeoutErr. moveReq in any other state is ignored.
- SNAP: latch gBoard into boardReg; idx=0; bestValid=0 -> SCAN.
- SCAN: one cell per cycle, idx 0..8, all evaluation on boardReg.
  - Occupied cell: invalid.
  - Empty cell scores:
    - 4 if any line through it has both other cells = myMark.
    - 3 if any line has both other cells = oppMark.
    - 2 for centre (idx 4).
    - 1 for a corner (0, 2, 6, 8).
    - 0 for an edge.
  - Score is the maximum applicable value.
  - Candidate replaces the best when !bestValid or score > bestScore. Ties keep the lower index.
  - After idx 8: bestValid -> ISSUE; otherwise noMove=1 -> DONE.
- ISSUE: playerWrite=1 for exactly one cycle; playerInput=bestIdx; counter=0 -> WAIT_ACK.
- WAIT_ACK:
  - gBoard cell at bestIdx != 00 -> DONE with moveDone=1.
  - Else counter++; counter reaching ACK_TIMEOUT -> timeoutErr=1 -> DONE with no moveDone.
- DONE: one cycle -> IDLE. moveDone is asserted during this single DONE cycle only.
- Latency: the edge sampling moveReq is edge 0; playerWrite is high in the cycle after edge 10 (1 SNAP + 9 SCAN cycles).
- gameIsDone=1 in SNAP/SCAN/ISSUE/WAIT_ACK: abort to IDLE next edge.
  - No playerWrite issued if not already in ISSUE.
  - moveDone and errors not set.
- Board changes during SCAN are ignored (snapshot semantics). WAIT_ACK watches the live gBoard.
- Lines: rows {0,1,2} {3,4,5} {6,7,8}; cols {0,3,6} {1,4,7} {2,5,8}; diagonals {0,4,8} {2,4,6}.
- Reset mid-operation returns to IDLE immediately with outputs cleared; no partial write strobe.

Optional Feature:
- AI_RANDOM_TIE_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every ph1 cycle.
  - In SCAN, an equal-score valid candidate replaces the best when lfsr[0]=1.
- Undefined: no LFSR; ties keep the lowest index as above.
- All other behaviour is identical in both builds.

Test Plan:
- Empty board (gBoard=0), isPlayer1=1, pulse moveReq -> playerWrite high the cycle after edge 10 with playerInput=4. Model sets cell 4=11 -> moveDone pulse, busy low next cycle.
- isPlayer1=1, cells 0,1=11, cells 3,4=10, rest empty -> playerInput=2 (win beats block at 5).
- isPlayer1=0, cells 0,4=11, cell 2=10 -> playerInput=8 (block).
- All 9 cells occupied -> no playerWrite; noMove=1 stays high until next moveReq; DONE reached after 9 SCAN cycles.
- Valid move but gBoard never updated -> timeoutErr=1 after ACK_TIMEOUT=15 WAIT_ACK cycles; moveDone stays 0.
- gameIsDone raised during SCAN idx 5, or reset during WAIT_ACK -> IDLE next edge (async for reset); playerWrite never asserted (gameIsDone case); all outputs 0.
